// File: rtl/debug_ctrl_bp_pkg.sv
// Shared command codes, FSM states and byte-enable helper
// for the breakpoint-capable debug controller.
package debug_pkg;

    localparam logic [3:0] FN_PAUSE     = 4'h1;
    localparam logic [3:0] FN_RESUME    = 4'h2;
    localparam logic [3:0] FN_STEP      = 4'h3;
    localparam logic [3:0] FN_RESET     = 4'h4;
    localparam logic [3:0] FN_STATUS    = 4'h5;
    localparam logic [3:0] FN_MEM_RD_B  = 4'h6;
    localparam logic [3:0] FN_MEM_RD_W  = 4'h7;
    localparam logic [3:0] FN_REG_RD    = 4'h8;
    localparam logic [3:0] FN_REG_WR    = 4'h9;
    localparam logic [3:0] FN_MEM_WR_B  = 4'hA;
    localparam logic [3:0] FN_MEM_WR_W  = 4'hB;
    localparam logic [3:0] FN_BR_PT_ADD = 4'hC;
    localparam logic [3:0] FN_BR_PT_RM  = 4'hD;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT_PAUSE,
        S_WAIT_RESUME,
        S_STEP_RUN,
        S_WAIT_MEM_RD,
        S_WAIT_MEM_WR,
        S_WAIT_REG_RD,
        S_WAIT_REG_WR,
        S_WAIT_RESET
    } state_t;

    function automatic logic [3:0] be_from_cmd(
        input logic [3:0] cmd,
        input logic [1:0] lane
    );
        logic [3:0] be;
        be = 4'b0000;
        if (cmd == FN_MEM_RD_W || cmd == FN_MEM_WR_W)
            be = 4'b1111;
        else if (cmd == FN_MEM_RD_B || cmd == FN_MEM_WR_B)
            be = 4'b0001 << lane;
        return be;
    endfunction

endpackage

// File: rtl/debug_ctrl_bp_if.sv
// Command/MCU bundle between sdec, the debug controller
// and the MCU debug port.
interface debug_ctrl_bp_if #(
    parameter int NUM_BP = 8,
    parameter int ADDR_W = 32
);
    localparam int IDX_W = $clog2(NUM_BP);

    logic [3:0]        cmd;
    logic [ADDR_W-1:0] addr;
    logic              in_valid;
    logic [ADDR_W-1:0] pc;
    logic              mcu_busy;

    logic              pause;
    logic              reset;
    logic              resume;
    logic              out_valid;
    logic              reg_rd;
    logic              reg_wr;
    logic              mem_rd;
    logic              mem_wr;
    logic [3:0]        mem_be;
    logic              ctrlr_busy;
    logic              mcu_paused;
    logic              bp_hit;
    logic [IDX_W-1:0]  bp_hit_idx;
    logic              bp_full;
    logic              err_tmo;

    modport master (
        output cmd, addr, in_valid, pc, mcu_busy,
        input  pause, reset, resume, out_valid,
        input  reg_rd, reg_wr, mem_rd, mem_wr, mem_be,
        input  ctrlr_busy, mcu_paused, bp_hit,
        input  bp_hit_idx, bp_full, err_tmo
    );

    modport slave (
        input  cmd, addr, in_valid, pc, mcu_busy,
        output pause, reset, resume, out_valid,
        output reg_rd, reg_wr, mem_rd, mem_wr, mem_be,
        output ctrlr_busy, mcu_paused, bp_hit,
        output bp_hit_idx, bp_full, err_tmo
    );

endinterface

// File: rtl/debug_ctrl_bp_table.sv
// Breakpoint address table: lowest-free-slot insert, indexed
// remove, and a combinational lowest-index PC match.
module bp_table #(
    parameter int NUM_BP = 8,
    parameter int ADDR_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_add,
    input  logic                       i_rm,
    input  logic [ADDR_W-1:0]          i_addr,
    input  logic [$clog2(NUM_BP)-1:0]  i_rm_idx,
    input  logic [ADDR_W-1:0]          i_pc,
    output logic                       o_hit,
    output logic [$clog2(NUM_BP)-1:0]  o_idx,
    output logic                       o_full
);
    localparam int IDX_W = $clog2(NUM_BP);

    logic [ADDR_W-1:0] r_entry [NUM_BP];
    logic [NUM_BP-1:0] r_valid;
    logic [IDX_W-1:0]  w_free_idx;
    logic              w_has_free;

    // Descending scans so the lowest index wins
    always_comb begin
        w_free_idx = '0;
        w_has_free = 1'b0;
        o_hit      = 1'b0;
        o_idx      = '0;
        for (int k = NUM_BP - 1; k >= 0; k--) begin
            if (!r_valid[k]) begin
                w_free_idx = IDX_W'(k);
                w_has_free = 1'b1;
            end
            if (r_valid[k] && r_entry[k] == i_pc) begin
                o_idx = IDX_W'(k);
                o_hit = 1'b1;
            end
        end
    end

    assign o_full = ~w_has_free;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int k = 0; k < NUM_BP; k++)
                r_entry[k] <= '0;
        end else begin
            if (i_add && w_has_free) begin
                r_entry[w_free_idx] <= i_addr;
                r_valid[w_free_idx] <= 1'b1;
            end
            if (i_rm)
                r_valid[i_rm_idx] <= 1'b0;
        end
    end

endmodule

// File: rtl/debug_ctrl_bp.sv
// UART debug controller: decodes sdec commands into MCU
// strobes and auto-pauses the MCU on breakpoint hits.
module debug_ctrl_bp
    import debug_pkg::*;
#(
    parameter int NUM_BP = 8,
    parameter int ADDR_W = 32,
    parameter int TMO_W  = 16
) (
    input  logic           clk,
    input  logic           rst,
    debug_ctrl_bp_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_BP);
    localparam logic [TMO_W-1:0] TMO_MAX = '1;

    state_t            r_state, w_next;
    logic [3:0]        r_cmd;
    logic [1:0]        r_addr;
    logic              r_paused;
    logic              r_sup;
    logic [ADDR_W-1:0] r_pc_res;
    logic [TMO_W-1:0]  r_tmo;
    logic [IDX_W-1:0]  r_hit_idx;

    logic             w_raw_hit, w_full, w_sup, w_match;
    logic             w_busy, w_accept, w_tmo;
    logic [IDX_W-1:0] w_hit_idx;
    logic             w_pause, w_reset, w_resume, w_ov;
    logic             w_rrd, w_rwr, w_mrd, w_mwr, w_err;
    logic [3:0]       w_be;
    logic             w_set_p, w_clr_p, w_arm, w_add, w_rm;

    bp_table #(
        .NUM_BP (NUM_BP),
        .ADDR_W (ADDR_W)
    ) u_bp (
        .clk      (clk),
        .rst      (rst),
        .i_add    (w_add),
        .i_rm     (w_rm),
        .i_addr   (bus.addr),
        .i_rm_idx (bus.addr[IDX_W-1:0]),
        .i_pc     (bus.pc),
        .o_hit    (w_raw_hit),
        .o_idx    (w_hit_idx),
        .o_full   (w_full)
    );

    // Suppression lasts only while PC sits where it was released
    assign w_sup    = r_sup & (bus.pc == r_pc_res);
    assign w_match  = ~rst & (r_state == S_IDLE) & ~r_paused
                    & ~w_sup & w_raw_hit;
    assign w_busy   = rst | (r_state != S_IDLE) | w_match;
    assign w_accept = bus.in_valid & ~w_busy;
    assign w_tmo    = (r_tmo == TMO_MAX);

    always_comb begin
        w_next   = r_state;
        w_pause  = 1'b0;
        w_reset  = 1'b0;
        w_resume = 1'b0;
        w_ov     = 1'b0;
        w_rrd    = 1'b0;
        w_rwr    = 1'b0;
        w_mrd    = 1'b0;
        w_mwr    = 1'b0;
        w_be     = 4'b0000;
        w_err    = 1'b0;
        w_set_p  = 1'b0;
        w_clr_p  = 1'b0;
        w_arm    = 1'b0;
        w_add    = 1'b0;
        w_rm     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_match) begin
                    w_pause = 1'b1;
                    w_ov    = 1'b1;
                    w_set_p = 1'b1;
                    w_next  = S_WAIT_PAUSE;
                end else if (w_accept) begin
                    unique case (bus.cmd)
                        FN_PAUSE: begin
                            w_pause = 1'b1;
                            w_ov    = 1'b1;
                            w_set_p = 1'b1;
                            w_next  = S_WAIT_PAUSE;
                        end
                        FN_RESUME: begin
                            w_resume = 1'b1;
                            w_ov     = 1'b1;
                            w_clr_p  = 1'b1;
                            w_arm    = 1'b1;
                            w_next   = S_WAIT_RESUME;
                        end
                        FN_RESET: begin
                            w_reset = 1'b1;
                            w_ov    = 1'b1;
                            w_clr_p = 1'b1;
                            w_arm   = 1'b1;
                            w_next  = S_WAIT_RESET;
                        end
                        FN_STEP: begin
                            if (r_paused) begin
                                w_resume = 1'b1;
                                w_ov     = 1'b1;
                                w_arm    = 1'b1;
                                w_next   = S_STEP_RUN;
                            end
                        end
                        FN_MEM_RD_B, FN_MEM_RD_W: begin
                            w_mrd  = 1'b1;
                            w_ov   = 1'b1;
                            w_be   = be_from_cmd(bus.cmd, bus.addr[1:0]);
                            w_next = S_WAIT_MEM_RD;
                        end
                        FN_MEM_WR_B, FN_MEM_WR_W: begin
                            w_mwr  = 1'b1;
                            w_ov   = 1'b1;
                            w_be   = be_from_cmd(bus.cmd, bus.addr[1:0]);
                            w_next = S_WAIT_MEM_WR;
                        end
                        FN_REG_RD: begin
                            w_rrd  = 1'b1;
                            w_ov   = 1'b1;
                            w_next = S_WAIT_REG_RD;
                        end
                        FN_REG_WR: begin
                            w_rwr  = 1'b1;
                            w_ov   = 1'b1;
                            w_next = S_WAIT_REG_WR;
                        end
                        FN_BR_PT_ADD: w_add = 1'b1;
                        FN_BR_PT_RM:
                            w_rm = (bus.addr[ADDR_W-1:IDX_W] == '0);
                        default: ;
                    endcase
                end
            end
            default: begin
                if (w_tmo) begin
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end else if (bus.mcu_busy) begin
                    w_ov = 1'b1;
                    case (r_state)
                        S_WAIT_PAUSE:  w_pause  = 1'b1;
                        S_WAIT_RESUME: w_resume = 1'b1;
                        S_STEP_RUN:    w_resume = 1'b1;
                        S_WAIT_RESET:  w_reset  = 1'b1;
                        S_WAIT_REG_RD: w_rrd    = 1'b1;
                        S_WAIT_REG_WR: w_rwr    = 1'b1;
                        S_WAIT_MEM_RD: w_mrd    = 1'b1;
                        S_WAIT_MEM_WR: w_mwr    = 1'b1;
                        default: ;
                    endcase
                    if (r_state == S_WAIT_MEM_RD ||
                        r_state == S_WAIT_MEM_WR)
                        w_be = be_from_cmd(r_cmd, r_addr);
                end else if (r_state == S_STEP_RUN) begin
                    w_pause = 1'b1;
                    w_ov    = 1'b1;
                    w_next  = S_WAIT_PAUSE;
                end else begin
                    w_next = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cmd     <= '0;
            r_addr    <= '0;
            r_paused  <= 1'b0;
            r_sup     <= 1'b0;
            r_pc_res  <= '0;
            r_tmo     <= '0;
            r_hit_idx <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cmd  <= bus.cmd;
                r_addr <= bus.addr[1:0];
            end
            if (w_set_p)
                r_paused <= 1'b1;
            else if (w_clr_p)
                r_paused <= 1'b0;
            if (w_arm) begin
                r_sup    <= 1'b1;
                r_pc_res <= bus.pc;
            end else begin
                r_sup <= w_sup;
            end
            if (w_match)
                r_hit_idx <= w_hit_idx;
            if (w_next != r_state)
                r_tmo <= '0;
            else if (r_state != S_IDLE && bus.mcu_busy)
                r_tmo <= r_tmo + 1'b1;
        end
    end

    assign bus.pause      = w_pause;
    assign bus.reset      = w_reset;
    assign bus.resume     = w_resume;
    assign bus.out_valid  = w_ov;
    assign bus.reg_rd     = w_rrd;
    assign bus.reg_wr     = w_rwr;
    assign bus.mem_rd     = w_mrd;
    assign bus.mem_wr     = w_mwr;
    assign bus.mem_be     = w_be;
    assign bus.ctrlr_busy = w_busy;
    assign bus.mcu_paused = r_paused;
    assign bus.bp_hit     = w_match;
    assign bus.bp_hit_idx = r_hit_idx;
    assign bus.bp_full    = w_full;
    assign bus.err_tmo    = w_err;

endmodule

// File: tb/tb_debug_ctrl_bp.sv
// Directed bench for debug_ctrl_bp: command issue/wait,
// breakpoints, step, timeout and async reset.
module tb_debug_ctrl_bp;
    import debug_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    // strobe vector {pause,reset,resume,ov,rrd,rwr,mrd,mwr}
    localparam logic [7:0] ST_NONE  = 8'h00;
    localparam logic [7:0] ST_MRD   = 8'h12;
    localparam logic [7:0] ST_MWR   = 8'h11;
    localparam logic [7:0] ST_RRD   = 8'h18;
    localparam logic [7:0] ST_PAUSE = 8'h90;
    localparam logic [7:0] ST_RES   = 8'h30;

    debug_ctrl_bp_if #(.NUM_BP(8), .ADDR_W(32)) bus();

    debug_ctrl_bp #(
        .NUM_BP (8),
        .ADDR_W (32),
        .TMO_W  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1);
    end

    function automatic logic [7:0] strb();
        return {bus.pause, bus.reset, bus.resume, bus.out_valid,
                bus.reg_rd, bus.reg_wr, bus.mem_rd, bus.mem_wr};
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input string tag, input logic [3:0] c,
                      input logic [31:0] a, input int nb,
                      input logic [7:0] es, input logic [3:0] eb);
        bus.cmd = c;
        bus.addr = a;
        bus.in_valid = 1'b1;
        #1;
        chk({tag, "_acc"}, 32'(strb()), 32'(es));
        chk({tag, "_acc_be"}, 32'(bus.mem_be), 32'(eb));
        step();
        bus.in_valid = 1'b0;
        bus.mcu_busy = (nb > 0);
        for (int k = 0; k < nb; k++) begin
            #1;
            chk({tag, "_hold"}, 32'(strb()), 32'(es));
            chk({tag, "_hold_be"}, 32'(bus.mem_be), 32'(eb));
            step();
            if (k == nb - 1) bus.mcu_busy = 1'b0;
        end
        #1;
        chk({tag, "_drop"}, 32'(strb()), 32'(ST_NONE));
        chk({tag, "_wbusy"}, 32'(bus.ctrlr_busy), 32'd1);
        step();
        #1;
        chk({tag, "_idle"}, 32'(bus.ctrlr_busy), 32'd0);
    endtask

    task automatic bp_cmd(input logic [3:0] c, input logic [31:0] a);
        bus.cmd = c;
        bus.addr = a;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.cmd = '0;
        bus.addr = '0;
        bus.in_valid = 1'b0;
        bus.pc = '0;
        bus.mcu_busy = 1'b0;
        #2;
        chk("rst_busy", 32'(bus.ctrlr_busy), 32'd1);
        chk("rst_strb", 32'(strb()), 32'(ST_NONE));
        chk("rst_paused", 32'(bus.mcu_paused), 32'd0);
        chk("rst_full", 32'(bus.bp_full), 32'd0);
        chk("rst_idx", 32'(bus.bp_hit_idx), 32'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_busy", 32'(bus.ctrlr_busy), 32'd0);

        // memory ops: word read, byte read, byte write
        op("mrdw", FN_MEM_RD_W, 32'h104, 3, ST_MRD, 4'b1111);
        op("mrdb", FN_MEM_RD_B, 32'h103, 3, ST_MRD, 4'b1000);
        op("mwrb", FN_MEM_WR_B, 32'h101, 1, ST_MWR, 4'b0010);

        // status is a no-op that never leaves idle
        bus.cmd = FN_STATUS;
        bus.in_valid = 1'b1;
        #1;
        chk("stat_strb", 32'(strb()), 32'(ST_NONE));
        chk("stat_busy", 32'(bus.ctrlr_busy), 32'd0);
        step();
        bus.in_valid = 1'b0;
        #1;
        chk("stat_after", 32'(bus.ctrlr_busy), 32'd0);

        // breakpoints at 0x40 / 0x80, hit at 0x40
        bp_cmd(FN_BR_PT_ADD, 32'h40);
        bp_cmd(FN_BR_PT_ADD, 32'h80);
        #1;
        chk("bp2_full", 32'(bus.bp_full), 32'd0);
        op("res1", FN_RESUME, 32'h0, 0, ST_RES, 4'b0000);
        bus.pc = 32'h3C;
        #1;
        chk("pc3c_hit", 32'(bus.bp_hit), 32'd0);
        step();
        bus.pc = 32'h40;
        #1;
        chk("pc40_hit", 32'(bus.bp_hit), 32'd1);
        chk("pc40_strb", 32'(strb()), 32'(ST_PAUSE));
        chk("pc40_busy", 32'(bus.ctrlr_busy), 32'd1);
        step();
        #1;
        chk("hit_pulse", 32'(bus.bp_hit), 32'd0);
        chk("hit_idx0", 32'(bus.bp_hit_idx), 32'd0);
        chk("hit_paused", 32'(bus.mcu_paused), 32'd1);
        step();

        // resume on the breakpoint: no re-hit until pc leaves
        op("res2", FN_RESUME, 32'h0, 0, ST_RES, 4'b0000);
        chk("res2_unp", 32'(bus.mcu_paused), 32'd0);
        step();
        #1;
        chk("sup_hit", 32'(bus.bp_hit), 32'd0);
        bus.pc = 32'h44;
        step();
        bus.pc = 32'h40;
        #1;
        chk("rehit", 32'(bus.bp_hit), 32'd1);
        step();
        step();
        #1;
        chk("rehit_paused", 32'(bus.mcu_paused), 32'd1);

        // single step while paused
        bus.cmd = FN_STEP;
        bus.in_valid = 1'b1;
        #1;
        chk("step_acc", 32'(strb()), 32'(ST_RES));
        step();
        bus.in_valid = 1'b0;
        bus.mcu_busy = 1'b1;
        #1;
        chk("step_run1", 32'(strb()), 32'(ST_RES));
        step();
        #1;
        chk("step_run2", 32'(strb()), 32'(ST_RES));
        step();
        bus.mcu_busy = 1'b0;
        #1;
        chk("step_pause", 32'(strb()), 32'(ST_PAUSE));
        step();
        #1;
        chk("step_wp", 32'(strb()), 32'(ST_NONE));
        step();
        #1;
        chk("step_idle", 32'(bus.ctrlr_busy), 32'd0);
        chk("step_paused", 32'(bus.mcu_paused), 32'd1);

        // step while running is a no-op
        op("res3", FN_RESUME, 32'h0, 0, ST_RES, 4'b0000);
        bus.cmd = FN_STEP;
        bus.in_valid = 1'b1;
        #1;
        chk("step_np_strb", 32'(strb()), 32'(ST_NONE));
        chk("step_np_busy", 32'(bus.ctrlr_busy), 32'd0);
        step();
        bus.in_valid = 1'b0;
        #1;
        chk("step_np_after", 32'(bus.ctrlr_busy), 32'd0);

        // fill the table, drop the 9th, reuse freed slot 3
        bus.pc = 32'h1000;
        step();
        for (int k = 2; k < 8; k++)
            bp_cmd(FN_BR_PT_ADD, 32'h500 + 32'(k));
        #1;
        chk("full8", 32'(bus.bp_full), 32'd1);
        bp_cmd(FN_BR_PT_ADD, 32'h999);
        bus.pc = 32'h999;
        #1;
        chk("drop9", 32'(bus.bp_hit), 32'd0);
        bus.pc = 32'h1000;
        bp_cmd(FN_BR_PT_RM, 32'd3);
        #1;
        chk("rm3_full", 32'(bus.bp_full), 32'd0);
        bp_cmd(FN_BR_PT_ADD, 32'h200);
        #1;
        chk("add200_full", 32'(bus.bp_full), 32'd1);
        bp_cmd(FN_BR_PT_RM, 32'd9);
        #1;
        chk("rm9_full", 32'(bus.bp_full), 32'd1);
        bus.pc = 32'h200;
        #1;
        chk("hit200", 32'(bus.bp_hit), 32'd1);
        step();
        step();
        #1;
        chk("idx200", 32'(bus.bp_hit_idx), 32'd3);
        op("res4", FN_RESUME, 32'h0, 0, ST_RES, 4'b0000);
        bus.pc = 32'h80;
        #1;
        chk("hit80", 32'(bus.bp_hit), 32'd1);
        step();
        #1;
        chk("idx80", 32'(bus.bp_hit_idx), 32'd1);
        step();

        // busy stuck: 15 busy cycles then err_tmo
        bus.cmd = FN_REG_RD;
        bus.in_valid = 1'b1;
        #1;
        chk("tmo_acc", 32'(strb()), 32'(ST_RRD));
        step();
        bus.in_valid = 1'b0;
        bus.mcu_busy = 1'b1;
        for (int k = 0; k < 15; k++) begin
            #1;
            chk("tmo_hold", 32'(strb()), 32'(ST_RRD));
            chk("tmo_noerr", 32'(bus.err_tmo), 32'd0);
            step();
        end
        #1;
        chk("tmo_err", 32'(bus.err_tmo), 32'd1);
        chk("tmo_drop", 32'(strb()), 32'(ST_NONE));
        step();
        #1;
        chk("tmo_pulse", 32'(bus.err_tmo), 32'd0);
        chk("tmo_idle", 32'(bus.ctrlr_busy), 32'd0);
        bus.mcu_busy = 1'b0;

        // async reset in the middle of a memory write
        bus.cmd = FN_MEM_WR_W;
        bus.addr = 32'h10;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.mcu_busy = 1'b1;
        #1;
        chk("mwr_wait", 32'(strb()), 32'(ST_MWR));
        rst = 1'b1;
        #1;
        chk("arst_strb", 32'(strb()), 32'(ST_NONE));
        chk("arst_be", 32'(bus.mem_be), 32'd0);
        chk("arst_busy", 32'(bus.ctrlr_busy), 32'd1);
        chk("arst_full", 32'(bus.bp_full), 32'd0);
        chk("arst_paused", 32'(bus.mcu_paused), 32'd0);
        chk("arst_idx", 32'(bus.bp_hit_idx), 32'd0);
        step();
        rst = 1'b0;
        bus.mcu_busy = 1'b0;
        #1;
        chk("arst_nohit", 32'(bus.bp_hit), 32'd0);
        chk("arst_idle", 32'(bus.ctrlr_busy), 32'd0);

        // breakpoint beats a simultaneous command
        bus.pc = 32'h0;
        bp_cmd(FN_BR_PT_ADD, 32'h300);
        bus.pc = 32'h300;
        bus.cmd = FN_MEM_RD_W;
        bus.addr = 32'h8;
        bus.in_valid = 1'b1;
        #1;
        chk("race_hit", 32'(bus.bp_hit), 32'd1);
        chk("race_strb", 32'(strb()), 32'(ST_PAUSE));
        chk("race_busy", 32'(bus.ctrlr_busy), 32'd1);
        step();
        bus.mcu_busy = 1'b1;
        #1;
        chk("race_wp", 32'(strb()), 32'(ST_PAUSE));
        chk("race_wbusy", 32'(bus.ctrlr_busy), 32'd1);
        step();
        bus.mcu_busy = 1'b0;
        #1;
        chk("race_wp_end", 32'(strb()), 32'(ST_NONE));
        step();
        #1;
        chk("race_acc", 32'(strb()), 32'(ST_MRD));
        chk("race_acc_be", 32'(bus.mem_be), 32'hF);
        step();
        bus.in_valid = 1'b0;
        #1;
        chk("race_wait", 32'(strb()), 32'(ST_NONE));
        step();
        #1;
        chk("race_idle", 32'(bus.ctrlr_busy), 32'd0);
        chk("race_paused", 32'(bus.mcu_paused), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/debug_ctrl_bp.md
Name: debug_ctrl_bp

Overview:
Parametrised successor to the UART debugger controller FSM. Sits between the serial decoder (sdec) and the MCU debug port. Decodes the same 4-bit command set into MCU strobes, and adds hardware breakpoint matching against the live PC with auto-pause. Also adds latched command/address, busy-wait timeout and status outputs.

Parameters:
NUM_BP, 8, breakpoint table depth (>=2, power of two)
ADDR_W, 32, address/PC width
TMO_W, 16, timeout counter width; abort after 2**TMO_W-1 busy cycles

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
cmd  in  4  command code from sdec (FN_* encoding)
addr  in  ADDR_W  command operand (mem address, reg index, bp address or bp slot index)
in_valid  in  1  command valid; held with cmd/addr until accepted
pc  in  ADDR_W  current MCU program counter
mcu_busy  in  1  MCU still servicing current debug op
pause  out  1  pause request to MCU
reset  out  1  MCU reset request
resume  out  1  resume request to MCU
out_valid  out  1  debug op valid to MCU
reg_rd, reg_wr, mem_rd, mem_wr  out  1 each  op strobes
mem_be  out  4  byte enables
ctrlr_busy  out  1  low only when a command can be accepted this cycle
mcu_paused  out  1  controller's view of MCU paused state
bp_hit  out  1  one-cycle pulse on breakpoint auto-pause
bp_hit_idx  out  $clog2(NUM_BP)  slot that caused last hit (held)
bp_full  out  1  all slots valid
err_tmo  out  1  one-cycle pulse on wait-state timeout

Behaviour:
- Reset (async, rst=1): state S_IDLE, all strobes/out_valid/mem_be 0, ctrlr_busy 1 while rst asserted, mcu_paused 0, all bp valid bits 0, bp_hit_idx 0, timeout counter 0, suppress flag 0. Reset mid-operation abandons the op; no strobe glitches after deassertion.
- Accept: a command is taken when in_valid & ~ctrlr_busy. ctrlr_busy=0 only in S_IDLE with no breakpoint match this cycle. On accept, cmd/addr latch into r_cmd/r_addr. All later states use the latched copies only.
- Issue cycle: the strobe and out_valid are driven combinationally in the accept cycle. The next state is the matching wait state. mem_be = 4'b1111 for word ops and 1<<addr[1:0] for byte ops; it is held from r_addr through the wait state.
- Wait states (S_WAIT_MEM_RD, S_WAIT_MEM_WR, S_WAIT_REG_RD, S_WAIT_REG_WR, S_WAIT_PAUSE, S_WAIT_RESUME, S_WAIT_RESET):
  - The op strobe, out_valid and mem_be stay asserted while mcu_busy=1.
  - The block returns to S_IDLE in the cycle after mcu_busy is sampled 0.
- FN_PAUSE: set mcu_paused.
- FN_RESUME: clear mcu_paused; arm the suppress flag.
- FN_RESET: assert reset; clear mcu_paused; arm the suppress flag.
- FN_STATUS: no MCU op; stays in S_IDLE; ctrlr_busy stays 0.
- FN_STEP:
  - If mcu_paused: resume+out_valid, go to S_STEP_RUN, and arm the suppress flag. Hold resume while mcu_busy. When mcu_busy=0, assert pause and go to S_WAIT_PAUSE; mcu_paused stays 1.
  - If not paused: no-op.
- FN_BR_PT_ADD: write addr into the lowest-index free slot and set its valid bit; single cycle. If bp_full, the command is dropped silently. Duplicate addresses are allowed.
- FN_BR_PT_RM: clear the valid bit of slot addr[$clog2(NUM_BP)-1:0]. If addr >= NUM_BP the command is ignored. Removing an empty slot is harmless.
- Undefined cmd codes: accepted, no-op.
- Breakpoint match:
  - Raw match = OR over slots of (valid & entry==pc). It counts only in S_IDLE with mcu_paused=0 and the suppress flag clear.
  - On a match: assert pause+out_valid, set mcu_paused, pulse bp_hit, latch the lowest matching index into bp_hit_idx, go to S_WAIT_PAUSE.
  - A match beats a simultaneous in_valid; the command waits (ctrlr_busy=1).
- Suppress flag: arming latches pc_at_resume. The flag clears the first cycle pc != pc_at_resume, so the MCU can leave the breakpoint it stopped on.
- Timeout: a counter clears on entry to any wait state and increments each cycle mcu_busy=1. At terminal count: pulse err_tmo, drop all strobes, return to S_IDLE. mcu_paused is left per the command's set/clear above.
- Adding/removing a slot that is currently matching takes effect the next cycle.

Decomposition:
- Package debug_pkg: FN_* command localparams, STATE enum (S_IDLE, S_WAIT_PAUSE, S_WAIT_RESUME, S_STEP_RUN, S_WAIT_MEM_RD, S_WAIT_MEM_WR, S_WAIT_REG_RD, S_WAIT_REG_WR, S_WAIT_RESET) and a be_from_cmd function.
- Sub-module bp_table (params NUM_BP, ADDR_W):
  - Holds storage, add/remove, and full flag.
  - Provides a lowest-index priority match giving hit/idx.
  - Matching is purely combinational; storage is the only sequential logic.

Test Plan:
- Accept cmd=7, addr=0x104, mcu_busy high 3 cycles → mem_rd, out_valid and mem_be=4'b1111 high for 4 cycles, then S_IDLE. Repeat with cmd=6, addr=0x103 → mem_be=4'b1000.
- Add bp 0x40 and 0x80, resume, drive pc 0x3C→0x40 → pause, bp_hit pulse, bp_hit_idx=0, mcu_paused=1. Resume with pc held at 0x40 → no re-hit until pc moves away and returns.
- Fill all 8 slots → bp_full=1. A 9th add is dropped. Remove addr=3, then add 0x200 → written into slot 3. Remove addr=9 → no change.
- Paused, cmd=3 → resume pulse, then pause, mcu_paused stays 1. Unpaused, cmd=3 → no strobes, ctrlr_busy=0.
- mcu_busy stuck high after cmd=8 with TMO_W=4 → err_tmo after 15 busy cycles, reg_rd drops, back to S_IDLE.
- Assert rst mid S_WAIT_MEM_WR → all outputs 0 and table cleared immediately. Also: in_valid and bp match in the same cycle → breakpoint wins, command accepted after pause completes.
